powerup_ctrl: RTL and testbench

- Consumer/controller end of the power-up spawn/eaten interface.
- Schedules power-up spawns by pulsing `spawn`.
- Detects puck overlap with the spawned power-up box using the box position and mode returned by the power-up block, then pulses `eaten`.
- Applies the captured effect to the player who last hit the puck for a fixed number of frames; sits between the power-up block, puck logic and paddle logic in the pong top level.

---
 rtl/powerup_ctrl.sv | 126 ++++++++++++
 tb/tb_powerup_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/powerup_ctrl.sv
// powerup_ctrl: schedules power-up spawns, detects puck pickup and applies the timed effect
module powerup_ctrl #(
    parameter int         PU_WIDTH      = 20,
    parameter int         PU_HEIGHT     = 20,
    parameter int         PUCK_SIZE     = 16,
    parameter logic [9:0] SPAWN_DELAY   = 10'd300,
    parameter logic [9:0] LIFETIME      = 10'd900,
    parameter logic [9:0] EFFECT_FRAMES = 10'd600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        game_on,
    input  logic        frame_tick,
    input  logic [10:0] puck_x,
    input  logic [9:0]  puck_y,
    input  logic [10:0] pu_x,
    input  logic [9:0]  pu_y,
    input  logic [1:0]  pu_mode,
    input  logic        last_hit,
    output logic        spawn,
    output logic        eaten,
    output logic [3:0]  effect_left,
    output logic [3:0]  effect_right,
    output logic [9:0]  frames_left
);
    typedef enum logic [1:0] {COOLDOWN, SPAWN, ARMED, ACTIVE} state_t;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d, frames_q, frames_d;
    logic [1:0]  mode_q, mode_d;
    logic        owner_q, owner_d, first_q, first_d;
    logic        spawn_q, spawn_d, eaten_q, eaten_d;
    logic [3:0]  eff_l_q, eff_l_d, eff_r_q, eff_r_d, eff_d;
    logic [11:0] px, ux;
    logic [10:0] py, uy;
    logic        overlap, hit;

    assign px = {1'b0, puck_x};
    assign ux = {1'b0, pu_x};
    assign py = {1'b0, puck_y};
    assign uy = {1'b0, pu_y};
    assign overlap = (px < ux + 12'(PU_WIDTH)) && (ux < px + 12'(PUCK_SIZE)) &&
                     (py < uy + 11'(PU_HEIGHT)) && (uy < py + 11'(PUCK_SIZE));
    assign hit = frame_tick && !first_q && overlap;

    // next-state, counter and registered-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        owner_d = owner_q;
        first_d = 1'b0;
        eaten_d = 1'b0;
        if (!game_on) begin
            state_d = COOLDOWN;
            cnt_d   = 10'd0;
            eaten_d = (state_q == ARMED);
        end else begin
            case (state_q)
                COOLDOWN: if (frame_tick) begin
                    state_d = (cnt_q >= SPAWN_DELAY - 10'd1) ? SPAWN : COOLDOWN;
                    cnt_d   = (cnt_q >= SPAWN_DELAY - 10'd1) ? 10'd0 : cnt_q + 10'd1;
                end
                SPAWN: begin
                    state_d = ARMED;
                    cnt_d   = LIFETIME;
                    first_d = 1'b1;
                end
                ARMED: if (hit) begin
                    state_d = ACTIVE;
                    cnt_d   = EFFECT_FRAMES;
                    mode_d  = pu_mode;
                    owner_d = last_hit;
                    eaten_d = 1'b1;
                end else if (frame_tick) begin
                    state_d = (cnt_q <= 10'd1) ? COOLDOWN : ARMED;
                    cnt_d   = (cnt_q <= 10'd1) ? 10'd0 : cnt_q - 10'd1;
                    eaten_d = (cnt_q <= 10'd1);
                end
                default: if (frame_tick) begin
                    state_d = (cnt_q <= 10'd1) ? COOLDOWN : ACTIVE;
                    cnt_d   = (cnt_q <= 10'd1) ? 10'd0 : cnt_q - 10'd1;
                end
            endcase
        end
        spawn_d  = (state_d == SPAWN);
        frames_d = (state_d == ARMED || state_d == ACTIVE) ? cnt_d : 10'd0;
        eff_d    = (state_d == ACTIVE) ? 4'b0001 << mode_d : 4'd0;
        eff_l_d  = owner_d ? 4'd0 : eff_d;
        eff_r_d  = owner_d ? eff_d : 4'd0;
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= COOLDOWN;
            cnt_q    <= 10'd0;
            mode_q   <= 2'd0;
            owner_q  <= 1'b0;
            first_q  <= 1'b0;
            spawn_q  <= 1'b0;
            eaten_q  <= 1'b0;
            eff_l_q  <= 4'd0;
            eff_r_q  <= 4'd0;
            frames_q <= 10'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            owner_q  <= owner_d;
            first_q  <= first_d;
            spawn_q  <= spawn_d;
            eaten_q  <= eaten_d;
            eff_l_q  <= eff_l_d;
            eff_r_q  <= eff_r_d;
            frames_q <= frames_d;
        end
    end

    // spawn is masked by game_on so a rally stop in the spawn cycle cannot leak a request
    assign spawn        = spawn_q && game_on;
    assign eaten        = eaten_q;
    assign effect_left  = eff_l_q;
    assign effect_right = eff_r_q;
    assign frames_left  = frames_q;
endmodule

// File: tb/tb_powerup_ctrl.sv
// tb_powerup_ctrl: randomized scoreboard bench for powerup_ctrl against a frame-level model
module tb_powerup_ctrl;
    logic        clk = 1'b0;
    logic        reset, game_on, frame_tick, last_hit;
    logic [10:0] puck_x, pu_x;
    logic [9:0]  puck_y, pu_y;
    logic [1:0]  pu_mode;
    logic        spawn, eaten;
    logic [3:0]  effect_left, effect_right;
    logic [9:0]  frames_left;

    powerup_ctrl dut (
        .clk(clk), .reset(reset), .game_on(game_on), .frame_tick(frame_tick),
        .puck_x(puck_x), .puck_y(puck_y), .pu_x(pu_x), .pu_y(pu_y),
        .pu_mode(pu_mode), .last_hit(last_hit), .spawn(spawn), .eaten(eaten),
        .effect_left(effect_left), .effect_right(effect_right), .frames_left(frames_left)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total = 0;

    typedef struct {int kind; int cyc;} ev_t;
    ev_t q[$];

    // frame-level reference: what the game is doing, in frames
    int cool = 0, life = 0, left = 0, mode = 0;
    bit armed = 0, active = 0, owner = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit touching();
        return int'(puck_x) < int'(pu_x) + 20 && int'(pu_x) < int'(puck_x) + 16 &&
               int'(puck_y) < int'(pu_y) + 20 && int'(pu_y) < int'(puck_y) + 16;
    endfunction

    task automatic push(input int kind);
        q.push_back('{kind, cyc + 1});
    endtask

    task automatic model_tick();
        if (!game_on) return;
        if (active) begin
            left--;
            if (left == 0) active = 0;
        end else if (armed) begin
            if (touching()) begin
                push(2);
                armed = 0; active = 1; left = 600;
                mode = int'(pu_mode); owner = last_hit;
            end else begin
                life--;
                if (life == 0) begin push(2); armed = 0; end
            end
        end else begin
            cool++;
            if (cool == 300) begin push(1); cool = 0; armed = 1; life = 900; end
        end
    endtask

    task automatic check_steady(input string tag);
        int e;
        e = active ? (1 << mode) : 0;
        chk({tag, "_frames_left"}, int'(frames_left), armed ? life : (active ? left : 0));
        chk({tag, "_effect_left"}, int'(effect_left), owner ? 0 : e);
        chk({tag, "_effect_right"}, int'(effect_right), owner ? e : 0);
    endtask

    task automatic frame();
        model_tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_steady("frame");
    endtask

    task automatic game_off(input int n);
        game_on = 1'b0;
        if (armed) push(2);
        armed = 0; active = 0; cool = 0;
        @(posedge clk); #1;
        check_steady("gameoff");
        repeat (n) frame();
        game_on = 1'b1;
    endtask

    task automatic do_reset(input bit with_tick);
        reset = 1'b1;
        frame_tick = with_tick;
        armed = 0; active = 0; cool = 0; owner = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        frame_tick = 1'b0;
        chk("reset_spawn", int'(spawn), 0);
        chk("reset_eaten", int'(eaten), 0);
        check_steady("reset");
    endtask

    task automatic put_puck(input int x, input int y);
        puck_x = 11'(x);
        puck_y = 10'(y);
    endtask

    // monitor: every spawn/eaten pulse must match the head of the expected queue
    always @(posedge clk) begin
        ev_t e;
        #1;
        if (q.size() != 0 && q[0].cyc < cyc) begin
            chk("pulse_missing", 0, q[0].kind);
            void'(q.pop_front());
        end
        if (spawn || eaten) begin
            if (spawn && eaten) chk("spawn_eaten_both", 1, 0);
            else if (q.size() == 0) chk("unexpected_pulse", spawn ? 1 : 2, 0);
            else begin
                e = q.pop_front();
                chk("pulse_kind", spawn ? 1 : 2, e.kind);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        reset = 1'b1; game_on = 1'b0; frame_tick = 1'b0;
        pu_x = 11'd700; pu_y = 10'd500; pu_mode = 2'd0; last_hit = 1'b0;
        put_puck(0, 0);
        repeat (3) begin @(posedge clk); #1; end
        do_reset(1'b0);
        game_on = 1'b1;
        // first spawn, then BOOST to the right player
        repeat (300) frame();
        chk("armed_lifetime", int'(frames_left), 900);
        put_puck(690, 495); pu_mode = 2'd1; last_hit = 1'b1;
        frame();
        chk("boost_right", int'(effect_right), 4'b0010);
        put_puck(0, 0);
        repeat (600) frame();
        chk("boost_cleared", int'(effect_right), 0);
        // edge touch is not a hit, one pixel in is
        repeat (300) frame();
        put_puck(720, 500); pu_mode = 2'd2;
        frame();
        put_puck(719, 500);
        frame();
        chk("none_bit_shown", int'(effect_right), 4'b0100);
        put_puck(0, 0);
        repeat (600) frame();
        // unclaimed power-up is withdrawn, then cooldown restarts
        repeat (300) frame();
        repeat (900) frame();
        repeat (300) frame();
        // SHIELD on the left, rally stops with 100 frames left
        put_puck(700, 500); pu_mode = 2'd3; last_hit = 1'b0;
        frame();
        put_puck(0, 0);
        repeat (500) frame();
        chk("shield_remaining", int'(frames_left), 100);
        game_off(50);
        repeat (300) frame();
        // reset while armed with an overlapping puck on a tick
        put_puck(700, 500);
        do_reset(1'b1);
        @(posedge clk); #1;
        chk("reset_no_eaten", int'(eaten), 0);
        repeat (3) begin @(posedge clk); #1; end
        // randomized rallies
        for (int i = 0; i < 2500; i++) begin
            if (i % 200 == 0) begin
                pu_x = 11'($urandom_range(100, 1800));
                pu_y = 10'($urandom_range(100, 900));
            end
            if ($urandom_range(0, 99) < 2) game_off($urandom_range(0, 3));
            else begin
                if ($urandom_range(0, 9) < 3)
                    put_puck(int'(pu_x) - 25 + $urandom_range(0, 50), int'(pu_y) - 25 + $urandom_range(0, 50));
                else put_puck(0, 0);
                pu_mode = 2'($urandom_range(0, 3));
                last_hit = 1'($urandom_range(0, 1));
                frame();
            end
        end
        repeat (5) begin @(posedge clk); #1; end
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
